shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Front-panel sequencer for the 32-bit barrel shifter on the board.
- Debounces the push buttons and latches operand, op and amount from the switches.
- Drives the shifter inputs, waits a settle window, then captures result and carry-out.
- Presents the captured values to the 7-segment display driver and the LED.

Parameters:
DB_CYCLES, 1000000, stable cycles a button must hold before a press is accepted (≥2)
SETTLE_CYCLES, 2, cycles the shifter inputs are held before shift_out is sampled (≥1)
DATA_W, 32, operand/result width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sw  in  DATA_W  raw switch bank
btn_data  in  1  raw button: latch sw as operand
btn_op  in  1  raw button: latch sw[31:29] as op, sw[23:16] as amount
btn_carry  in  1  raw button: toggle carry-in flag
btn_go  in  1  raw button: start shift
shift_data  out  DATA_W  to shifter: operand
shift_num  out  8  to shifter: shift amount
shift_op  out  3  to shifter: op code (passed through unmodified)
carry_flag  out  1  to shifter: carry-in
shift_out  in  DATA_W  from shifter: combinational result
shift_carry_out  in  1  from shifter: carry-out
disp_data  out  DATA_W  to display driver
led_carry  out  1  captured carry-out
busy  out  1  high in EXEC
done  out  1  one-cycle pulse when a result is captured

Behaviour:
- Reset (async assert, sync release): every output register and every internal register is 0. State=IDLE.
- Button conditioning: 2-flop synchronizer, then debounce counter per button.
  - A level change is accepted after DB_CYCLES consecutive stable samples.
  - A press is a single-cycle pulse on the accepted 0→1 transition.
  - Releases generate nothing. Holding a button produces exactly one pulse.
- Register updates, each effective the cycle after its press pulse:
  - btn_data pulse: shift_data<=sw. Accepted in IDLE/DONE, ignored in EXEC.
  - btn_op pulse: shift_op<=sw[31:29], shift_num<=sw[23:16]. Accepted in IDLE/DONE, ignored in EXEC.
  - btn_carry pulse: carry_flag toggles. Accepted in IDLE/DONE, ignored in EXEC.
- State machine:
  - IDLE --go pulse--> EXEC.
  - EXEC: busy=1. Counter runs 0..SETTLE_CYCLES-1. On the last count, disp_data<=shift_out, led_carry<=shift_carry_out, done pulses for 1 cycle, then → DONE.
  - DONE --go pulse--> EXEC, which re-runs with the current registers.
  - busy=0 in IDLE and DONE.
- Latency: go pulse to done = SETTLE_CYCLES+1 cycles. disp_data is valid in the done cycle.
- Simultaneous pulses in the same cycle:
  - Any load pulse (data/op/carry) and go together: the load is applied first and EXEC uses the new value (load takes effect on the EXEC entry edge).
  - Multiple load pulses together: all are applied.
- go pulse in EXEC: ignored, not queued.
- disp_data and led_carry hold their value until the next capture; they are not cleared on a load.
- Reset mid-EXEC: no capture, done stays 0, state=IDLE, debounce counters and synchronizers are cleared.

Optional Feature:
Macro SHIFT_SEQ_CHAIN_EN.
- Defined: a go pulse in DONE first copies shift_data<=disp_data (the previous result), then enters EXEC. Repeated go presses chain shifts. A btn_data pulse in the same cycle as go wins over the copy: shift_data<=sw.
- Undefined: a go pulse in DONE re-runs the shift on the unchanged shift_data.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC with sw=0xFFFFFFFF → all outputs 0, state IDLE, no done pulse.
- Debounce (DB_CYCLES=4): btn_data bouncing 1,0,1 at 1-cycle intervals, then steady 1 for 10 cycles, sw=0x12345678 → exactly one load, shift_data=0x12345678.
- Basic run (SETTLE_CYCLES=2, model shifter: logical left shift): shift_data=0x0000_00F0, op=3'b000, num=4, go → busy for 2 cycles, done at cycle 3, disp_data=0x0000_0F00, led_carry=0.
- Carry toggle: two btn_carry presses → carry_flag 0→1→0. Press in EXEC → carry_flag unchanged.
- go during EXEC and btn_op during EXEC → ignored. Exactly one done pulse; shift_num unchanged.
- SHIFT_SEQ_CHAIN_EN defined, shifter shl 4, data 0x1 → go ×3 → disp_data 0x10, 0x100, 0x1000. With the macro undefined: 0x10 every run.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Front-panel sequencer for the board's barrel shifter. Four push buttons are
// synchronised and debounced. The switch bank is latched as the operand and as
// the op/amount fields. On a go press the shifter inputs are held for a settle
// window. Then the combinational shifter result and its carry-out are captured
// for the 7-segment display and the LED.
//
// Optional build macro:
//   SHIFT_SEQ_CHAIN_EN  - a go press in DONE first copies the previous result
//                         into shift_data, so repeated go presses chain shifts.
//                         A data press in the same cycle takes priority.
//
// Parameters:
//   DB_CYCLES      stable samples needed before a button level change counts (>=2)
//   SETTLE_CYCLES  cycles the shifter inputs are held before capture (>=1)
//   DATA_W         operand/result width (>=24, op field in the top 3 bits,
//                  amount field in bits 23:16)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sw                raw switch bank
//   btn_data          raw button: latch sw as operand
//   btn_op            raw button: latch op (sw[DATA_W-1 -: 3]) and amount (sw[23:16])
//   btn_carry         raw button: toggle the carry-in flag
//   btn_go            raw button: start a shift
//   shift_data        operand to the shifter
//   shift_num         shift amount to the shifter
//   shift_op          op code to the shifter, passed through unmodified
//   carry_flag        carry-in to the shifter
//   shift_out         combinational result from the shifter
//   shift_carry_out   carry-out from the shifter
//   disp_data         captured result for the display driver
//   led_carry         captured carry-out
//   busy              high while a shift is settling (EXEC)
//   done              one-cycle pulse in the cycle after a capture
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// shift_seq_ctrl_db
//
// Per-button conditioner: a 2-flop synchroniser followed by a debounce counter.
// The counter counts consecutive synchronised samples that differ from the
// accepted level. It restarts whenever the input agrees with the accepted
// level. A press is a one-cycle pulse on an accepted 0->1 change. An accepted
// release produces no pulse.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   btn_raw      raw, asynchronous button level
//   press        one-cycle press pulse
// -----------------------------------------------------------------------------
module shift_seq_ctrl_db #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This is the DB_CYCLES-th consecutive differing sample.
                level_q <= sync_q2;
                cnt_q   <= '0;
                press   <= sync_q2;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// -----------------------------------------------------------------------------
// shift_seq_ctrl (top)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, no result captured yet; loads accepted
// EXEC    | shifter inputs held for SETTLE_CYCLES; loads and go ignored
// DONE    | result captured and displayed; loads accepted, go re-runs
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int DB_CYCLES     = 1000000,
    parameter int SETTLE_CYCLES = 2,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_data,
    input  logic              btn_op,
    input  logic              btn_carry,
    input  logic              btn_go,
    output logic [DATA_W-1:0] shift_data,
    output logic [7:0]        shift_num,
    output logic [2:0]        shift_op,
    output logic              carry_flag,
    input  logic [DATA_W-1:0] shift_out,
    input  logic              shift_carry_out,
    output logic [DATA_W-1:0] disp_data,
    output logic              led_carry,
    output logic              busy,
    output logic              done
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SET_W-1:0] settle_q;
    logic [SET_W-1:0] settle_d;
    logic             capture;
    logic             load_ok;
    logic             chain_copy;

    logic data_p;
    logic op_p;
    logic carry_p;
    logic go_p;

    shift_seq_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_data),
        .press   (data_p)
    );

    shift_seq_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_op (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_op),
        .press   (op_p)
    );

    shift_seq_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_carry (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_carry),
        .press   (carry_p)
    );

    shift_seq_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_go (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_go),
        .press   (go_p)
    );

    // Next-state and settle-counter logic
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        capture    = 1'b0;
        load_ok    = (state_q != ST_EXEC);
        chain_copy = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go_p) begin
                    state_d  = ST_EXEC;
                    settle_d = '0;
                end
            end
            ST_EXEC: begin
                if (settle_q == SETTLE_LAST) begin
                    capture  = 1'b1;
                    state_d  = ST_DONE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (go_p) begin
                    state_d  = ST_EXEC;
                    settle_d = '0;
`ifdef SHIFT_SEQ_CHAIN_EN
                    chain_copy = 1'b1;
`else
                    chain_copy = 1'b0;
`endif
                end
            end
            default: begin
                state_d  = ST_IDLE;
                settle_d = '0;
            end
        endcase
    end

    assign busy = (state_q == ST_EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Operand/config registers. Loads land on the same edge as EXEC entry, so
    // a load pressed together with go is used by that run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_data <= '0;
            shift_op   <= 3'd0;
            shift_num  <= 8'd0;
            carry_flag <= 1'b0;
        end else begin
            if (load_ok && data_p) begin
                shift_data <= sw;
            end else if (chain_copy) begin
                shift_data <= disp_data;
            end
            if (load_ok && op_p) begin
                shift_op  <= sw[DATA_W-1 -: 3];
                shift_num <= sw[23:16];
            end
            if (load_ok && carry_p) begin
                carry_flag <= ~carry_flag;
            end
        end
    end

    // Result capture: values hold until the next capture, independent of loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data <= '0;
            led_carry <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= capture;
            if (capture) begin
                disp_data <= shift_out;
                led_carry <= shift_carry_out;
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Drives two copies of shift_seq_ctrl from the same buttons and switches:
//   u_dut    SETTLE_CYCLES=2, the main instance
//   u_dut_l  SETTLE_CYCLES=16, whose long EXEC window leaves room for a
//            debounced go re-press
// Each instance has its own behavioural shifter:
//   op 0  logical left,  carry = last bit shifted out
//   op 1  logical right, carry = last bit shifted out
//   other result = ~data, carry = carry_flag
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int DB   = 4;
    localparam int ST   = 2;
    localparam int ST_L = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sw = '0;
    logic        btn_data = 1'b0;
    logic        btn_op = 1'b0;
    logic        btn_carry = 1'b0;
    logic        btn_go = 1'b0;

    logic [31:0] shift_data, disp_data, shift_out;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic        carry_flag, led_carry, busy, done, shift_carry_out;

    logic [31:0] shift_data_l, disp_data_l, shift_out_l;
    logic [7:0]  shift_num_l;
    logic [2:0]  shift_op_l;
    logic        carry_flag_l, led_carry_l, busy_l, done_l, shift_carry_out_l;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [32:0] shifter_model(input logic [31:0] d, input logic [7:0] n,
                                                  input logic [2:0] op, input logic cin);
        logic [63:0] t;
        case (op)
            3'd0: begin
                t = {32'b0, d} << n;
                return {t[32], t[31:0]};
            end
            3'd1: begin
                t = {d, 32'b0} >> n;
                return {t[31], t[63:32]};
            end
            default: return {cin, ~d};
        endcase
    endfunction

    assign {shift_carry_out, shift_out} = shifter_model(shift_data, shift_num, shift_op, carry_flag);
    assign {shift_carry_out_l, shift_out_l} =
        shifter_model(shift_data_l, shift_num_l, shift_op_l, carry_flag_l);

    shift_seq_ctrl #(.DB_CYCLES(DB), .SETTLE_CYCLES(ST), .DATA_W(32)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sw              (sw),
        .btn_data        (btn_data),
        .btn_op          (btn_op),
        .btn_carry       (btn_carry),
        .btn_go          (btn_go),
        .shift_data      (shift_data),
        .shift_num       (shift_num),
        .shift_op        (shift_op),
        .carry_flag      (carry_flag),
        .shift_out       (shift_out),
        .shift_carry_out (shift_carry_out),
        .disp_data       (disp_data),
        .led_carry       (led_carry),
        .busy            (busy),
        .done            (done)
    );

    shift_seq_ctrl #(.DB_CYCLES(DB), .SETTLE_CYCLES(ST_L), .DATA_W(32)) u_dut_l (
        .clk             (clk),
        .rst_n           (rst_n),
        .sw              (sw),
        .btn_data        (btn_data),
        .btn_op          (btn_op),
        .btn_carry       (btn_carry),
        .btn_go          (btn_go),
        .shift_data      (shift_data_l),
        .shift_num       (shift_num_l),
        .shift_op        (shift_op_l),
        .carry_flag      (carry_flag_l),
        .shift_out       (shift_out_l),
        .shift_carry_out (shift_carry_out_l),
        .disp_data       (disp_data_l),
        .led_carry       (led_carry_l),
        .busy            (busy_l),
        .done            (done_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mask: [0] data, [1] op, [2] carry, [3] go
    task automatic set_btns(input logic [3:0] m);
        btn_data  = m[0];
        btn_op    = m[1];
        btn_carry = m[2];
        btn_go    = m[3];
    endtask

    task automatic press(input logic [3:0] m);
        set_btns(m);
        tick(DB + 6);
        set_btns(4'b0000);
        tick(DB + 6);
    endtask

    // Raise go (plus any extra buttons) just after an edge and watch the main
    // instance for 40 edges. done_at is the edge index where done is first seen.
    task automatic run_go(input logic [3:0] extra, output int done_at,
                          output int busy_n, output int done_n);
        done_at = 0;
        busy_n  = 0;
        done_n  = 0;
        set_btns(extra | 4'b1000);
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
            if (i == 10) set_btns(4'b0000);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " shift_data"}, shift_data, 32'h0);
        check({tag, " shift_num"}, {24'h0, shift_num}, 32'h0);
        check({tag, " shift_op"}, {29'h0, shift_op}, 32'h0);
        check({tag, " carry_flag"}, {31'h0, carry_flag}, 32'h0);
        check({tag, " disp_data"}, disp_data, 32'h0);
        check({tag, " led_carry"}, {31'h0, led_carry}, 32'h0);
        check({tag, " busy"}, {31'h0, busy}, 32'h0);
        check({tag, " done"}, {31'h0, done}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] d;
        logic [2:0]  op;
        logic [7:0]  n;
        logic        cpress;
        logic [31:0] exp_res;
        logic        exp_cout;
        logic        exp_cflag;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          done_at, busy_n, done_n, changes;
        int          dn_l, da_l, dn_m;
        logic [31:0] prev;
        logic [31:0] exp_chain;

        vecs[0] = '{32'h0000_00F0, 3'd0, 8'd4,   1'b0, 32'h0000_0F00, 1'b0, 1'b0};
        vecs[1] = '{32'h8000_0001, 3'd0, 8'd1,   1'b0, 32'h0000_0002, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0001, 3'd1, 8'd1,   1'b0, 32'h4000_0000, 1'b1, 1'b0};
        vecs[3] = '{32'h1234_5678, 3'd1, 8'd8,   1'b0, 32'h0012_3456, 1'b0, 1'b0};
        vecs[4] = '{32'hA5A5_A5A5, 3'd0, 8'd0,   1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0};
        vecs[5] = '{32'hF0F0_F0F0, 3'd3, 8'd0,   1'b1, 32'h0F0F_0F0F, 1'b1, 1'b1};
        vecs[6] = '{32'hDEAD_BEEF, 3'd0, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_FFFF, 3'd1, 8'd200, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[8] = '{32'h0000_0000, 3'd2, 8'd0,   1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

        // Reset state
        tick(3);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick(2);
        check_zero_outputs("post-reset");

        // Bouncing data button: one accepted load
        sw = 32'h1234_5678;
        changes = 0;
        prev = shift_data;
        btn_data = 1'b1; tick(1);
        btn_data = 1'b0; tick(1);
        btn_data = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (shift_data !== prev) changes++;
            prev = shift_data;
        end
        btn_data = 1'b0;
        tick(DB + 6);
        check("bounce data value", shift_data, 32'h1234_5678);
        check("bounce data loads", changes, 1);

        // Carry toggles, including a bouncing press
        press(4'b0100);
        check("carry 1st press", {31'h0, carry_flag}, 32'h1);
        press(4'b0100);
        check("carry 2nd press", {31'h0, carry_flag}, 32'h0);
        changes = 0;
        prev = {31'h0, carry_flag};
        btn_carry = 1'b1; tick(1);
        btn_carry = 1'b0; tick(1);
        btn_carry = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if ({31'h0, carry_flag} !== prev) changes++;
            prev = {31'h0, carry_flag};
        end
        btn_carry = 1'b0;
        tick(DB + 6);
        check("carry bounce toggles", changes, 1);
        press(4'b0100);
        check("carry back to 0", {31'h0, carry_flag}, 32'h0);

        // Table-driven shifts
        for (int v = 0; v < 9; v++) begin
            sw = vecs[v].d;
            press(4'b0001);
            sw = {vecs[v].op, 5'b0, vecs[v].n, 16'h0};
            press(4'b0010);
            if (vecs[v].cpress) press(4'b0100);
            check($sformatf("v%0d shift_data", v), shift_data, vecs[v].d);
            check($sformatf("v%0d shift_op", v), {29'h0, shift_op}, {29'h0, vecs[v].op});
            check($sformatf("v%0d shift_num", v), {24'h0, shift_num}, {24'h0, vecs[v].n});
            check($sformatf("v%0d carry_flag", v), {31'h0, carry_flag}, {31'h0, vecs[v].exp_cflag});
            run_go(4'b0000, done_at, busy_n, done_n);
            check($sformatf("v%0d done latency", v), done_at, 9);
            check($sformatf("v%0d busy cycles", v), busy_n, ST);
            check($sformatf("v%0d done pulses", v), done_n, 1);
            check($sformatf("v%0d disp_data", v), disp_data, vecs[v].exp_res);
            check($sformatf("v%0d led_carry", v), {31'h0, led_carry}, {31'h0, vecs[v].exp_cout});
        end

        // Load during DONE leaves the displayed result alone
        sw = 32'h0BAD_F00D;
        press(4'b0001);
        check("load keeps disp_data", disp_data, 32'hFFFF_FFFF);
        check("load in DONE", shift_data, 32'h0BAD_F00D);
        sw = 32'h0000_0000;
        press(4'b0001);

        // go, op and carry pressed during EXEC of the long instance
        sw = {3'b101, 5'b0, 8'h77, 16'h0};
        dn_l = 0; da_l = 0; dn_m = 0;
        btn_go = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick(1);
            if (done_l) begin
                dn_l++;
                if (da_l == 0) da_l = i;
            end
            if (done) dn_m++;
            if (i == 1) begin btn_op = 1'b1; btn_carry = 1'b1; end
            if (i == 7) btn_go = 1'b0;
            if (i == 12) btn_go = 1'b1;
            if (i == 20) begin btn_op = 1'b0; btn_carry = 1'b0; end
            if (i == 30) btn_go = 1'b0;
        end
        tick(DB + 6);
        check("exec-ignore done pulses", dn_l, 1);
        check("exec-ignore done latency", da_l, ST_L + 7);
        check("exec-ignore shift_num", {24'h0, shift_num_l}, 32'h0);
        check("exec-ignore shift_op", {29'h0, shift_op_l}, 32'h2);
        check("exec-ignore carry_flag", {31'h0, carry_flag_l}, 32'h0);
        check("main op ignored in EXEC", {24'h0, shift_num}, 32'h0);
        check("main go re-run from DONE", dn_m, 2);

        // Multiple simultaneous loads, then reset in the middle of a long EXEC
        sw = 32'hFFFF_FFFF;
        press(4'b0111);
        check("multi-load data", shift_data, 32'hFFFF_FFFF);
        check("multi-load op", {29'h0, shift_op}, 32'h7);
        check("multi-load num", {24'h0, shift_num}, 32'hFF);
        check("multi-load carry", {31'h0, carry_flag}, 32'h1);
        btn_go = 1'b1;
        tick(10);
        btn_go = 1'b0;
        tick(2);
        check("long busy before reset", {31'h0, busy_l}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid-exec reset");
        check("mid-exec reset long disp", disp_data_l, 32'h0);
        check("mid-exec reset long busy", {31'h0, busy_l}, 32'h0);
        check("mid-exec reset long done", {31'h0, done_l}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        dn_l = 0; dn_m = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (done_l || busy_l) dn_l++;
            if (done || busy) dn_m++;
        end
        check("no activity after reset long", dn_l, 0);
        check("no activity after reset main", dn_m, 0);
        check("long disp after reset", disp_data_l, 32'h0);

        // Repeated go from IDLE with shl 4 on 0x1
        sw = 32'h0000_0001;
        press(4'b0001);
        sw = 32'h0004_0000;
        press(4'b0010);
        exp_chain = 32'h1;
        for (int r = 0; r < 3; r++) begin
`ifdef SHIFT_SEQ_CHAIN_EN
            exp_chain = exp_chain << 4;
`else
            exp_chain = 32'h10;
`endif
            run_go(4'b0000, done_at, busy_n, done_n);
            check($sformatf("repeat go %0d disp", r), disp_data, exp_chain);
            check($sformatf("repeat go %0d done", r), done_n, 1);
        end

        // Data load together with go: new operand is used by that run
        sw = 32'h0000_0003;
        run_go(4'b0001, done_at, busy_n, done_n);
        check("load+go shift_data", shift_data, 32'h0000_0003);
        check("load+go disp", disp_data, 32'h0000_0030);
        check("load+go latency", done_at, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
